i2s_transceiver: RTL and testbench
==================================

// Module: i2s_transceiver
// PURPOSE
//  Parametrised I2S master transceiver for the FIR audio path on Basys3.
//  - Generates mclk/sclk/lrck from the system clock.
//  - Deserialises stereo ADC samples and serialises stereo DAC samples.
//  - Exchanges parallel samples with the core via a valid pulse (ADC side) and valid/ready (DAC side).
//  - Replaces the fixed-ratio I2S logic inside the FIR engine.
// PARAMETERS
//  SAMPLE_WIDTH  24  bits per audio sample; must be <= SLOT_WIDTH-1
//  SLOT_WIDTH    32  sclk periods per channel slot (frame = 2*SLOT_WIDTH)
//  MCLK_DIV      4   clk cycles per mclk period; even, >= 2
//  SCLK_RATIO    4   mclk periods per sclk period; >= 1 (P = MCLK_DIV*SCLK_RATIO clk/sclk)
// PORTS
//  clk          in   1    system clock
//  reset        in   1    asynchronous, active-high reset
//  enable       in   1    run clocks/transfers; low = idle
//  mclk         out  1    codec master clock
//  sclk         out  1    serial bit clock
//  lrck         out  1    word select; 0 = left, 1 = right
//  adc          in   1    serial data from codec ADC
//  dac          out  1    serial data to codec DAC
//  adcLeft      out  SW   last captured left sample
//  adcRight     out  SW   last captured right sample
//  adcValid     out  1    1-cycle pulse: new adcLeft/adcRight pair
//  dacLeft      in   SW   left sample to transmit
//  dacRight     in   SW   right sample to transmit
//  dacValid     in   1    dacLeft/dacRight offered
//  dacReady     out  1    holding register empty; transfer when valid&&ready
//  dacUnderrun  out  1    1-cycle pulse: frame started with empty holding register
// BEHAVIOUR
//  - Reset: all outputs 0 except dacReady=1; holding register empty; shift registers 0.
//  - Timing base: single frame counter fc, 0..2*SLOT_WIDTH*P-1, wraps. Increments only while enable=1.
//  - Derived outputs (all registered, mutually aligned):
//    - mclk = (fc%MCLK_DIV) >= MCLK_DIV/2.
//    - sclk = (fc%P) >= P/2.
//    - bitIdx = fc/P; lrck = bitIdx >= SLOT_WIDTH; slot position k = bitIdx%SLOT_WIDTH.
//  - Standard I2S one-bit delay:
//    - Position k=1..SAMPLE_WIDTH carries sample bit SAMPLE_WIDTH-k (MSB first).
//    - Positions 0 and >SAMPLE_WIDTH carry 0.
//  - TX: dac updates on the sclk falling edge (fc%P==0).
//  - RX: adc sampled on the clk edge where sclk rises (fc%P==P/2), only at data positions.
//  - adcValid: asserted the cycle after the right LSB is captured. adcLeft/adcRight update in that same cycle and hold until the next frame.
//  - DAC handshake:
//    - dacReady = holding register empty.
//    - valid&&ready loads dacLeft/dacRight into holding; dacValid ignored while full.
//  - Frame start (fc==0 with enable=1, incl. first cycle after enable rises):
//    - Holding full: contents move to TX shift regs; holding empties.
//    - Holding empty: TX repeats previous frame's samples (0 after reset) and dacUnderrun pulses.
//    - Frame start uses holding state before the edge. A sample accepted on the frame-start edge goes to the next frame.
//  - enable low:
//    - fc forced to 0; mclk/sclk/lrck/dac driven 0 next cycle.
//    - Partial RX frame discarded, no adcValid.
//    - Holding register keeps its contents and can still be filled.
//  - enable deasserted mid-frame: stops immediately. Re-enable restarts at fc=0 with a frame-start transfer.
//  - reset mid-frame: immediate return to reset values; no adcValid or dacUnderrun pulse.
// CONFIGURATION
//  I2S_LOOPBACK_EN defined:
//    - Adds input port loopback (1 bit).
//    - When loopback=1, RX samples the internal dac signal instead of adc.
//    - adcLeft/adcRight then equal the samples transmitted in the same frame.
//  I2S_LOOPBACK_EN undefined: no loopback port; RX always samples adc.
// TESTING (defaults: P=16, frame=1024 clk)
//  1. Clocks: reset, enable=1
//     -> mclk period 4 clk, sclk period 16 clk, lrck period 1024 clk; all 50% duty.
//     -> lrck low for the first 512 clk.
//  2. TX: preload dacLeft=24'hA5F00F, dacRight=24'h5A0FF0, then enable
//     -> at sclk rises, positions 1..24 give A5F00F/5A0FF0 MSB first.
//     -> positions 0 and 25..31 read 0.
//  3. RX: codec model drives left 24'h123456, right 24'hFEDCBA
//     -> one adcValid per frame; adcLeft=123456, adcRight=FEDCBA.
//  4. Underrun: no dacValid before frame 2
//     -> dacUnderrun pulses at fc=0; frame 2 retransmits frame-1 samples.
//     -> dacValid on the fc==0 edge is still counted as an underrun.
//  5. enable=0 at bitIdx 10
//     -> mclk/sclk/lrck/dac low next cycle; no adcValid.
//     -> re-enable: lrck low, full frame sent from MSB.
//  6. reset pulse mid-frame -> all outputs reset values immediately.
//     With I2S_LOOPBACK_EN and loopback=1: adcLeft/adcRight == transmitted dacLeft/dacRight.

Source files
------------

// File: rtl/i2s_transceiver.sv
// i2s_transceiver: I2S master transceiver for the FIR audio path.
// Generates mclk/sclk/lrck from clk using one frame counter. The receiver
// turns the serial ADC stream into stereo sample pairs. The transmitter
// sends stereo DAC samples, which the core hands over through a one-deep
// holding register with a valid/ready handshake.
// Optional feature macro: I2S_LOOPBACK_EN adds a 'loopback' input. When it
// is high, the receiver samples the internal dac bit instead of the adc pin.
module i2s_transceiver #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int MCLK_DIV     = 4,
    parameter int SCLK_RATIO   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    mclk,
    output logic                    sclk,
    output logic                    lrck,
    input  logic                    adc,
    output logic                    dac,
    output logic [SAMPLE_WIDTH-1:0] adcLeft,
    output logic [SAMPLE_WIDTH-1:0] adcRight,
    output logic                    adcValid,
    input  logic [SAMPLE_WIDTH-1:0] dacLeft,
    input  logic [SAMPLE_WIDTH-1:0] dacRight,
    input  logic                    dacValid,
    output logic                    dacReady,
    output logic                    dacUnderrun
`ifdef I2S_LOOPBACK_EN
    ,
    input  logic                    loopback
`endif
);

    localparam int P     = MCLK_DIV * SCLK_RATIO;
    localparam int FRAME = 2 * SLOT_WIDTH * P;
    localparam int FCW   = $clog2(FRAME);
    localparam int SW    = SAMPLE_WIDTH;

    localparam logic [FCW-1:0] C_FC_MAX = FCW'(FRAME - 1);
    localparam logic [FCW-1:0] C_MDIV   = FCW'(MCLK_DIV);
    localparam logic [FCW-1:0] C_MHALF  = FCW'(MCLK_DIV / 2);
    localparam logic [FCW-1:0] C_P      = FCW'(P);
    localparam logic [FCW-1:0] C_PHALF  = FCW'(P / 2);
    localparam logic [FCW-1:0] C_SLOT   = FCW'(SLOT_WIDTH);
    localparam logic [FCW-1:0] C_SW     = FCW'(SAMPLE_WIDTH);
    localparam logic [SW-1:0]  C_ONE    = SW'(1);

    // Handshake: a sample pair transfers on any clk edge where dacValid && dacReady.
    // dacReady is high whenever the holding register is empty. dacValid is ignored
    // while the register is full, and the offer may be held or withdrawn freely.

    logic [FCW-1:0] r_fc;
    logic           r_mclk;
    logic           r_sclk;
    logic           r_lrck;
    logic           r_dac;
    logic           r_hold_full;
    logic [SW-1:0]  r_hold_left;
    logic [SW-1:0]  r_hold_right;
    logic [SW-1:0]  r_tx_left;
    logic [SW-1:0]  r_tx_right;
    logic           r_underrun;
    logic [SW-1:0]  r_rx_sr;
    logic [SW-1:0]  r_rx_left;
    logic [SW-1:0]  r_adc_left;
    logic [SW-1:0]  r_adc_right;
    logic           r_adc_valid;

    logic [FCW-1:0] w_fc_next;
    logic           w_frame_start;
    logic           w_accept;

    // Next-count view: the registered outputs are computed from it, so they line up with r_fc.
    logic [FCW-1:0] w_nx_bit_idx;
    logic           w_nx_right;
    logic [FCW-1:0] w_nx_pos;
    logic           w_nx_data;
    logic [SW-1:0]  w_nx_word;
    logic [SW-1:0]  w_nx_mask;
    logic           w_nx_bit;

    // Current-count view: the receiver uses it.
    logic [FCW-1:0] w_cur_bit_idx;
    logic           w_cur_right;
    logic [FCW-1:0] w_cur_pos;
    logic           w_cur_data;
    logic [SW-1:0]  w_cur_mask;
    logic           w_rx_in;
    logic           w_rx_strobe;
    logic           w_rx_last_right;
    logic [SW-1:0]  w_rx_word;

    assign w_fc_next     = !enable ? '0 : ((r_fc == C_FC_MAX) ? '0 : r_fc + 1'b1);
    assign w_frame_start = enable && (r_fc == '0);
    assign w_accept      = dacValid && !r_hold_full;

    // Position k carries sample bit SW-k (one-bit I2S delay). Positions 0 and >SW carry 0.
    assign w_nx_bit_idx = w_fc_next / C_P;
    assign w_nx_right   = w_nx_bit_idx >= C_SLOT;
    assign w_nx_pos     = w_nx_bit_idx % C_SLOT;
    assign w_nx_data    = (w_nx_pos != '0) && (w_nx_pos <= C_SW);
    assign w_nx_word    = w_nx_right ? r_tx_right : r_tx_left;
    assign w_nx_mask    = C_ONE << (C_SW - w_nx_pos);
    assign w_nx_bit     = w_nx_data && (|(w_nx_word & w_nx_mask));

    assign w_cur_bit_idx = r_fc / C_P;
    assign w_cur_right   = w_cur_bit_idx >= C_SLOT;
    assign w_cur_pos     = w_cur_bit_idx % C_SLOT;
    assign w_cur_data    = (w_cur_pos != '0) && (w_cur_pos <= C_SW);
    assign w_cur_mask    = C_ONE << (C_SW - w_cur_pos);

`ifdef I2S_LOOPBACK_EN
    assign w_rx_in = loopback ? r_dac : adc;
`else
    assign w_rx_in = adc;
`endif

    // Sample mid-bit, on the clk edge where sclk rises.
    assign w_rx_strobe     = enable && w_cur_data && ((r_fc % C_P) == C_PHALF);
    assign w_rx_last_right = w_rx_strobe && w_cur_right && (w_cur_pos == C_SW);
    assign w_rx_word       = (r_rx_sr & ~w_cur_mask) | ({SW{w_rx_in}} & w_cur_mask);

    assign mclk        = r_mclk;
    assign sclk        = r_sclk;
    assign lrck        = r_lrck;
    assign dac         = r_dac;
    assign adcLeft     = r_adc_left;
    assign adcRight    = r_adc_right;
    assign adcValid    = r_adc_valid;
    assign dacReady    = ~r_hold_full;
    assign dacUnderrun = r_underrun;

    // Frame counter: runs through one stereo frame while enabled, held at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fc <= '0;
        end else begin
            r_fc <= w_fc_next;
        end
    end

    // Serial clocks and data bit. A zero count yields all-low, which gives the idle state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mclk <= 1'b0;
            r_sclk <= 1'b0;
            r_lrck <= 1'b0;
            r_dac  <= 1'b0;
        end else begin
            r_mclk <= (w_fc_next % C_MDIV) >= C_MHALF;
            r_sclk <= (w_fc_next % C_P) >= C_PHALF;
            r_lrck <= w_nx_right;
            r_dac  <= w_nx_bit;
        end
    end

    // Holding register and TX sample registers. An empty holding register at frame start repeats the old pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_full  <= 1'b0;
            r_hold_left  <= '0;
            r_hold_right <= '0;
            r_tx_left    <= '0;
            r_tx_right   <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && !r_hold_full;
            if (w_frame_start && r_hold_full) begin
                r_tx_left   <= r_hold_left;
                r_tx_right  <= r_hold_right;
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_left  <= dacLeft;
                r_hold_right <= dacRight;
                r_hold_full  <= 1'b1;
            end
        end
    end

    // Receiver: assemble each slot bit by bit, then publish the stereo pair after the right LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sr     <= '0;
            r_rx_left   <= '0;
            r_adc_left  <= '0;
            r_adc_right <= '0;
            r_adc_valid <= 1'b0;
        end else begin
            r_adc_valid <= w_rx_last_right;
            if (!enable) begin
                r_rx_sr   <= '0;
                r_rx_left <= '0;
            end else if (w_rx_strobe) begin
                r_rx_sr <= w_rx_word;
                if (!w_cur_right && (w_cur_pos == C_SW)) begin
                    r_rx_left <= w_rx_word;
                end
                if (w_rx_last_right) begin
                    r_adc_left  <= r_rx_left;
                    r_adc_right <= w_rx_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transceiver.sv
// tb_i2s_transceiver: directed bench for i2s_transceiver at default parameters
// (P = 16 clk per sclk, 1024 clk per frame).
module tb_i2s_transceiver;

    localparam int SW    = 24;
    localparam int P     = 16;
    localparam int FRAME = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          adc = 1'b0;
    logic          dacValid = 1'b0;
    logic [SW-1:0] dacLeft = '0;
    logic [SW-1:0] dacRight = '0;
    logic          mclk, sclk, lrck, dac, adcValid, dacReady, dacUnderrun;
    logic [SW-1:0] adcLeft, adcRight;
`ifdef I2S_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    int            tests = 0;
    int            fails = 0;
    int            fc_m = 0;
    logic [SW-1:0] codec_l = 24'h123456;
    logic [SW-1:0] codec_r = 24'hFEDCBA;

    i2s_transceiver dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mclk(mclk), .sclk(sclk), .lrck(lrck),
        .adc(adc), .dac(dac),
        .adcLeft(adcLeft), .adcRight(adcRight), .adcValid(adcValid),
        .dacLeft(dacLeft), .dacRight(dacRight), .dacValid(dacValid),
        .dacReady(dacReady), .dacUnderrun(dacUnderrun)
`ifdef I2S_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    always #5 clk = ~clk;

    // Codec model: bit on the adc line for a given frame count.
    function automatic logic codec_bit(input int fc, input logic [SW-1:0] l, input logic [SW-1:0] r);
        int bi;
        int k;
        logic [SW-1:0] w;
        bi = fc / P;
        k  = bi % 32;
        w  = (bi >= 32) ? r : l;
        if (k >= 1 && k <= SW) return w[SW-k];
        return 1'b0;
    endfunction

    // One clock: wait for the negedge, advance the count model, drive the codec bit.
    task automatic step();
        @(negedge clk);
        if (reset || !enable) fc_m = 0;
        else fc_m = (fc_m + 1) % FRAME;
        adc = codec_bit(fc_m, codec_l, codec_r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        dacValid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        fc_m = 0;
    endtask

    // Runs one full frame from fc=0 and records what the DUT sent and reported.
    task automatic capture_frame(output logic [SW-1:0] tx_l, output logic [SW-1:0] tx_r,
                                 output int zero_bits, output int ur_cnt, output int ur_at,
                                 output int av_cnt, output int av_at, output int clk_bad,
                                 output logic [SW-1:0] av_l, output logic [SW-1:0] av_r);
        int k;
        tx_l = '0; tx_r = '0; zero_bits = 0; ur_cnt = 0; ur_at = -1;
        av_cnt = 0; av_at = -1; clk_bad = 0; av_l = '0; av_r = '0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i == 0) dacValid = 1'b0;
            if (fc_m % P == P / 2) begin
                k = (fc_m / P) % 32;
                if (k >= 1 && k <= SW) begin
                    if (fc_m >= FRAME / 2) tx_r[SW-k] = dac;
                    else tx_l[SW-k] = dac;
                end else if (dac !== 1'b0) begin
                    zero_bits++;
                end
            end
            if (dacUnderrun === 1'b1) begin ur_cnt++; ur_at = fc_m; end
            if (adcValid === 1'b1) begin av_cnt++; av_at = fc_m; av_l = adcLeft; av_r = adcRight; end
            if (mclk !== ((fc_m % 4) >= 2) || sclk !== ((fc_m % P) >= P / 2) || lrck !== (fc_m >= FRAME / 2))
                clk_bad++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        tests++; if (mclk !== 1'b0) begin fails++; $display("FAIL reset_mclk got %b exp 0", mclk); end
        tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk got %b exp 0", sclk); end
        tests++; if (lrck !== 1'b0) begin fails++; $display("FAIL reset_lrck got %b exp 0", lrck); end
        tests++; if (dac !== 1'b0) begin fails++; $display("FAIL reset_dac got %b exp 0", dac); end
        tests++; if (adcValid !== 1'b0) begin fails++; $display("FAIL reset_adcValid got %b exp 0", adcValid); end
        tests++; if (adcLeft !== '0) begin fails++; $display("FAIL reset_adcLeft got %h exp 0", adcLeft); end
        tests++; if (adcRight !== '0) begin fails++; $display("FAIL reset_adcRight got %h exp 0", adcRight); end
        tests++; if (dacReady !== 1'b1) begin fails++; $display("FAIL reset_dacReady got %b exp 1", dacReady); end
        tests++; if (dacUnderrun !== 1'b0) begin fails++; $display("FAIL reset_dacUnderrun got %b exp 0", dacUnderrun); end
        repeat (2) step();
        reset = 1'b0;
        fc_m = 0;
        repeat (4) step();
        tests++; if ({mclk, sclk, lrck, dac} !== 4'b0000) begin fails++; $display("FAIL idle_clocks got %b exp 0000", {mclk, sclk, lrck, dac}); end
    endtask

    task automatic test_clocks();
        int m_rise, m_high, s_rise, s_high, l_rise, l_high, first_l, bad;
        logic pm, ps, pl;
        m_rise = 0; m_high = 0; s_rise = 0; s_high = 0; l_rise = 0; l_high = 0; first_l = -1; bad = 0;
        do_reset();
        enable = 1'b1;
        pm = 1'b0; ps = 1'b0; pl = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (mclk && !pm) m_rise++;
            if (sclk && !ps) s_rise++;
            if (lrck && !pl) l_rise++;
            if (mclk) m_high++;
            if (sclk) s_high++;
            if (lrck) l_high++;
            if (lrck === 1'b1 && first_l < 0) first_l = i + 1;
            if (mclk !== ((fc_m % 4) >= 2) || sclk !== ((fc_m % P) >= P / 2) || lrck !== (fc_m >= FRAME / 2)) bad++;
            pm = mclk; ps = sclk; pl = lrck;
        end
        tests++; if (m_rise != 512) begin fails++; $display("FAIL mclk_rises got %0d exp 512", m_rise); end
        tests++; if (m_high != 1024) begin fails++; $display("FAIL mclk_high got %0d exp 1024", m_high); end
        tests++; if (s_rise != 128) begin fails++; $display("FAIL sclk_rises got %0d exp 128", s_rise); end
        tests++; if (s_high != 1024) begin fails++; $display("FAIL sclk_high got %0d exp 1024", s_high); end
        tests++; if (l_rise != 2) begin fails++; $display("FAIL lrck_rises got %0d exp 2", l_rise); end
        tests++; if (l_high != 1024) begin fails++; $display("FAIL lrck_high got %0d exp 1024", l_high); end
        tests++; if (first_l != 512) begin fails++; $display("FAIL lrck_first_high got %0d exp 512", first_l); end
        tests++; if (bad != 0) begin fails++; $display("FAIL clock_phase got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_tx();
        logic [SW-1:0] tl, tr, al, ar;
        int zb, uc, ua, ac, aa, cb;
        do_reset();
        dacLeft = 24'hA5F00F; dacRight = 24'h5A0FF0; dacValid = 1'b1;
        tests++; if (dacReady !== 1'b1) begin fails++; $display("FAIL preload_ready got %b exp 1", dacReady); end
        step();
        dacValid = 1'b0;
        tests++; if (dacReady !== 1'b0) begin fails++; $display("FAIL preload_full got %b exp 0", dacReady); end
        enable = 1'b1;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if (tl !== 24'hA5F00F) begin fails++; $display("FAIL tx_left got %h exp a5f00f", tl); end
        tests++; if (tr !== 24'h5A0FF0) begin fails++; $display("FAIL tx_right got %h exp 5a0ff0", tr); end
        tests++; if (zb != 0) begin fails++; $display("FAIL tx_zero_positions got %0d nonzero exp 0", zb); end
        tests++; if (uc != 0) begin fails++; $display("FAIL tx_no_underrun got %0d exp 0", uc); end
        tests++; if (cb != 0) begin fails++; $display("FAIL tx_clock_phase got %0d exp 0", cb); end
        tests++; if (dacReady !== 1'b1) begin fails++; $display("FAIL tx_ready_after got %b exp 1", dacReady); end
    endtask

    task automatic test_underrun();
        logic [SW-1:0] tl, tr, al, ar;
        int zb, uc, ua, ac, aa, cb;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if (uc != 1) begin fails++; $display("FAIL ur_count got %0d exp 1", uc); end
        tests++; if (ua != 1) begin fails++; $display("FAIL ur_position got %0d exp 1", ua); end
        tests++; if ({tl, tr} !== {24'hA5F00F, 24'h5A0FF0}) begin fails++; $display("FAIL ur_repeat got %h/%h exp a5f00f/5a0ff0", tl, tr); end
        dacLeft = 24'h111111; dacRight = 24'h222222; dacValid = 1'b1;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if (uc != 1) begin fails++; $display("FAIL ur_edge_count got %0d exp 1", uc); end
        tests++; if ({tl, tr} !== {24'hA5F00F, 24'h5A0FF0}) begin fails++; $display("FAIL ur_edge_data got %h/%h exp a5f00f/5a0ff0", tl, tr); end
        tests++; if (dacReady !== 1'b0) begin fails++; $display("FAIL ur_edge_held got %b exp 0", dacReady); end
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if (uc != 0) begin fails++; $display("FAIL next_no_underrun got %0d exp 0", uc); end
        tests++; if ({tl, tr} !== {24'h111111, 24'h222222}) begin fails++; $display("FAIL next_data got %h/%h exp 111111/222222", tl, tr); end
        tests++; if (dacReady !== 1'b1) begin fails++; $display("FAIL next_ready got %b exp 1", dacReady); end
    endtask

    task automatic test_rx();
        logic [SW-1:0] tl, tr, al, ar;
        int zb, uc, ua, ac, aa, cb;
        do_reset();
        codec_l = 24'h123456; codec_r = 24'hFEDCBA;
        enable = 1'b1;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if (ac != 1) begin fails++; $display("FAIL rx_valid_count got %0d exp 1", ac); end
        tests++; if (aa != 905) begin fails++; $display("FAIL rx_valid_position got %0d exp 905", aa); end
        tests++; if (al !== 24'h123456) begin fails++; $display("FAIL rx_left got %h exp 123456", al); end
        tests++; if (ar !== 24'hFEDCBA) begin fails++; $display("FAIL rx_right got %h exp fedcba", ar); end
        codec_l = 24'h0A0B0C; codec_r = 24'hF0E0D0;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if (ac != 1) begin fails++; $display("FAIL rx2_valid_count got %0d exp 1", ac); end
        tests++; if ({al, ar} !== {24'h0A0B0C, 24'hF0E0D0}) begin fails++; $display("FAIL rx2_pair got %h/%h exp 0a0b0c/f0e0d0", al, ar); end
        tests++; if (adcLeft !== 24'h0A0B0C) begin fails++; $display("FAIL rx_hold got %h exp 0a0b0c", adcLeft); end
    endtask

    task automatic test_enable_stop();
        logic [SW-1:0] tl, tr, al, ar;
        int zb, uc, ua, ac, aa, cb, idle_bad, av_seen;
        do_reset();
        dacLeft = 24'hC3FFFF; dacRight = 24'h3C0001; dacValid = 1'b1;
        step();
        dacValid = 1'b0;
        enable = 1'b1;
        repeat (170) step();
        tests++; if ({mclk, sclk, lrck, dac} !== 4'b1101) begin fails++; $display("FAIL pre_stop got %b exp 1101", {mclk, sclk, lrck, dac}); end
        enable = 1'b0;
        step();
        tests++; if ({mclk, sclk, lrck, dac} !== 4'b0000) begin fails++; $display("FAIL stop_outputs got %b exp 0000", {mclk, sclk, lrck, dac}); end
        tests++; if (dacReady !== 1'b1) begin fails++; $display("FAIL stop_ready got %b exp 1", dacReady); end
        dacLeft = 24'h800001; dacRight = 24'h400003; dacValid = 1'b1;
        step();
        dacValid = 1'b0;
        idle_bad = 0; av_seen = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if ({mclk, sclk, lrck, dac} !== 4'b0000) idle_bad++;
            if (adcValid !== 1'b0) av_seen++;
        end
        tests++; if (idle_bad != 0) begin fails++; $display("FAIL idle_outputs got %0d bad cycles exp 0", idle_bad); end
        tests++; if (av_seen != 0) begin fails++; $display("FAIL idle_adcValid got %0d exp 0", av_seen); end
        tests++; if (dacReady !== 1'b0) begin fails++; $display("FAIL idle_fill got %b exp 0", dacReady); end
        enable = 1'b1;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        tests++; if ({tl, tr} !== {24'h800001, 24'h400003}) begin fails++; $display("FAIL restart_data got %h/%h exp 800001/400003", tl, tr); end
        tests++; if (uc != 0) begin fails++; $display("FAIL restart_underrun got %0d exp 0", uc); end
        tests++; if (cb != 0) begin fails++; $display("FAIL restart_clock_phase got %0d exp 0", cb); end
        tests++; if (zb != 0) begin fails++; $display("FAIL restart_zero_positions got %0d exp 0", zb); end
        tests++; if (ac != 1) begin fails++; $display("FAIL restart_valid_count got %0d exp 1", ac); end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] tl, tr, al, ar;
        int zb, uc, ua, ac, aa, cb, pulses;
        do_reset();
        dacLeft = 24'h0F0F0F; dacRight = 24'hF0F0F0; dacValid = 1'b1;
        step();
        dacValid = 1'b0;
        enable = 1'b1;
        capture_frame(tl, tr, zb, uc, ua, ac, aa, cb, al, ar);
        dacValid = 1'b1;
        step();
        dacValid = 1'b0;
        while (fc_m != 602) step();
        tests++; if ({mclk, sclk, lrck} !== 3'b111) begin fails++; $display("FAIL mid_clocks got %b exp 111", {mclk, sclk, lrck}); end
        tests++; if (adcLeft !== codec_l) begin fails++; $display("FAIL mid_adcLeft got %h exp %h", adcLeft, codec_l); end
        tests++; if (dacReady !== 1'b0) begin fails++; $display("FAIL mid_ready got %b exp 0", dacReady); end
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        tests++; if ({mclk, sclk, lrck, dac, adcValid, dacUnderrun} !== 6'b0) begin fails++; $display("FAIL async_bits got %b exp 000000", {mclk, sclk, lrck, dac, adcValid, dacUnderrun}); end
        tests++; if ({adcLeft, adcRight} !== '0) begin fails++; $display("FAIL async_samples got %h/%h exp 0/0", adcLeft, adcRight); end
        tests++; if (dacReady !== 1'b1) begin fails++; $display("FAIL async_ready got %b exp 1", dacReady); end
        repeat (3) step();
        reset = 1'b0;
        fc_m = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (adcValid !== 1'b0 || dacUnderrun !== 1'b0) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL post_reset_pulses got %0d exp 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_tx();
        test_underrun();
        test_rx();
        test_enable_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
